branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_pkg.sv | 16 +
 rtl/branch_predictor_if.sv | 30 +++
 rtl/branch_predictor_sat_counter_2b.sv | 19 +
 rtl/branch_predictor.sv | 73 +++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types and geometry for the direct-mapped 2-bit branch predictor.
package branch_pred_pkg;

   localparam int unsigned PC_W    = 16;
   localparam int unsigned IDX_W   = 3;
   localparam int unsigned TAG_W   = 12;
   localparam int unsigned ENTRIES = 8;

   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } ctr_e;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/decode-side signal bundle between the pipeline (master) and the predictor (slave).
interface branch_predictor_if;
   import branch_pred_pkg::*;

   logic [PC_W-1:0] PC_curr;
   logic [PC_W-1:0] IF_ID_PC_curr;
   logic            Branch;
   logic            IF_ID_stall;
   logic            actual_taken;
   logic [PC_W-1:0] actual_target;
   logic            IF_ID_predicted_taken;
   logic [PC_W-1:0] IF_ID_predicted_target;
   logic            predicted_taken;
   logic [PC_W-1:0] predicted_target;
   logic            branch_mispredicted;
   logic [15:0]     mispredict_count;

   modport master (
      output PC_curr, IF_ID_PC_curr, Branch, IF_ID_stall, actual_taken, actual_target,
             IF_ID_predicted_taken, IF_ID_predicted_target,
      input  predicted_taken, predicted_target, branch_mispredicted, mispredict_count
   );

   modport slave (
      input  PC_curr, IF_ID_PC_curr, Branch, IF_ID_stall, actual_taken, actual_target,
             IF_ID_predicted_taken, IF_ID_predicted_target,
      output predicted_taken, predicted_target, branch_mispredicted, mispredict_count
   );

endinterface

// File: rtl/branch_predictor_sat_counter_2b.sv
// Combinational next-state for a 2-bit saturating taken/not-taken counter.
import branch_pred_pkg::*;

module sat_counter_2b (
   input  ctr_e cur,
   input  logic taken,
   output ctr_e next
);

   always_comb begin
      next = cur;
      if (taken) begin
         if (cur != STRONG_T) next = ctr_e'(cur + 2'd1);
      end else begin
         if (cur != STRONG_NT) next = ctr_e'(cur - 2'd1);
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// 8-entry direct-mapped branch predictor: combinational IF lookup, update and
// misprediction check on the resolving ID branch.
import branch_pred_pkg::*;

module branch_predictor (
   input  logic              clk,
   input  logic              rst,
   branch_predictor_if.slave bp
);

   logic              valid_q [ENTRIES];
   logic [TAG_W-1:0]  tag_q   [ENTRIES];
   ctr_e              ctr_q   [ENTRIES];
   logic [PC_W-1:0]   tgt_q   [ENTRIES];
   logic [15:0]       cnt_q, cnt_d;

   logic [IDX_W-1:0]  lu_idx, up_idx;
   logic [TAG_W-1:0]  lu_tag, up_tag;
   logic              lu_hit, up_hit, resolve;
   ctr_e              ctr_nxt;

   assign lu_idx  = bp.PC_curr[IDX_W:1];
   assign lu_tag  = bp.PC_curr[PC_W-1:IDX_W+1];
   assign up_idx  = bp.IF_ID_PC_curr[IDX_W:1];
   assign up_tag  = bp.IF_ID_PC_curr[PC_W-1:IDX_W+1];
   assign resolve = bp.Branch & ~bp.IF_ID_stall;

   always_comb begin
      lu_hit              = valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag);
      up_hit              = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
      bp.predicted_taken  = lu_hit & ctr_q[lu_idx][1];
      bp.predicted_target = bp.predicted_taken ? tgt_q[lu_idx] : '0;
      bp.branch_mispredicted = resolve &
         ((bp.actual_taken != bp.IF_ID_predicted_taken) |
          (bp.actual_taken & (bp.IF_ID_predicted_target != bp.actual_target)));
      cnt_d = (bp.branch_mispredicted && cnt_q != '1) ? cnt_q + 16'd1 : cnt_q;
   end

   assign bp.mispredict_count = cnt_q;

   sat_counter_2b u_ctr (
      .cur   (ctr_q[up_idx]),
      .taken (bp.actual_taken),
      .next  (ctr_nxt)
   );

   // Lookup reads registered state, so a same-index update shows up next cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            ctr_q[i]   <= STRONG_NT;
            tgt_q[i]   <= '0;
         end
         cnt_q <= '0;
      end else begin
         if (resolve) begin
            if (up_hit) begin
               ctr_q[up_idx] <= ctr_nxt;
               if (bp.actual_taken) tgt_q[up_idx] <= bp.actual_target;
            end else begin
               valid_q[up_idx] <= 1'b1;
               tag_q[up_idx]   <= up_tag;
               ctr_q[up_idx]   <= bp.actual_taken ? WEAK_T : WEAK_NT;
               tgt_q[up_idx]   <= bp.actual_target;
            end
         end
         cnt_q <= cnt_d;
      end
   end

endmodule
